// File: rtl/blinky_led_blinker.sv
`default_nettype none
// ============================================================================
//  Module   : blinky_led_blinker
//  Purpose  : Avalon-MM LED port with per-bit blink mask. A 24-bit counter
//             and a phase bit make a square wave; masked LED bits are ANDed
//             with the phase, unmasked bits follow DATA directly.
//  Revision : 1.0 - initial release
// ============================================================================
module blinky_led_blinker #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] DATA_RESET   = '0,
  parameter logic [23:0]      PERIOD_RESET = 24'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0] c_ADDR_DATA   = 2'd0;
  localparam logic [1:0] c_ADDR_MASK   = 2'd1;
  localparam logic [1:0] c_ADDR_PERIOD = 2'd2;
  localparam logic [1:0] c_ADDR_SETCLR = 2'd3;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [23:0]      r_period;
  logic [23:0]      r_cnt;
  logic             r_phase;
  logic [31:0]      r_readdata;
  logic [WIDTH-1:0] r_out;

  logic             w_wr;
  logic             w_wr_data;
  logic             w_wr_mask;
  logic             w_wr_period;
  logic             w_wr_setclr;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wrap;
  logic [31:0]      w_rd_next;
  logic [WIDTH-1:0] w_out_next;
  logic             w_unused_wdata;

  // Write decode: a single-cycle write with no wait states
  assign w_wr        = chipselect & ~write_n;
  assign w_wr_data   = w_wr & (address == c_ADDR_DATA);
  assign w_wr_mask   = w_wr & (address == c_ADDR_MASK);
  assign w_wr_period = w_wr & (address == c_ADDR_PERIOD);
  assign w_wr_setclr = w_wr & (address == c_ADDR_SETCLR);

  assign w_set = writedata[WIDTH-1:0];
  assign w_clr = writedata[WIDTH+15:16];

  // Bits of writedata not used by any register for narrow LED widths
  assign w_unused_wdata = ^writedata;

  // Wrap is compared only against PERIOD-1, so an out-of-range count runs on
  // until the 24-bit counter rolls over or PERIOD is rewritten
  assign w_wrap = (r_cnt == (r_period - 24'd1));

  // DATA / MASK / PERIOD register writes; SETCLR applies clear after set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= DATA_RESET;
      r_mask   <= '0;
      r_period <= PERIOD_RESET;
    end else begin
      if (w_wr_data) begin
        r_data <= writedata[WIDTH-1:0];
      end else if (w_wr_setclr) begin
        r_data <= (r_data | w_set) & ~w_clr;
      end
      if (w_wr_mask) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      if (w_wr_period) begin
        r_period <= writedata[23:0];
      end
    end
  end

  // Blink engine: counter and phase, resynchronised by any PERIOD write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 24'd0;
      r_phase <= 1'b1;
    end else if (w_wr_period || (r_period == 24'd0)) begin
      r_cnt   <= 24'd0;
      r_phase <= 1'b1;
    end else if (w_wrap) begin
      r_cnt   <= 24'd0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 24'd1;
    end
  end

  // Read mux: every address is decoded each cycle, unused bits are zero
  always_comb begin
    w_rd_next = '0;
    case (address)
      c_ADDR_DATA:   w_rd_next[WIDTH-1:0] = r_data;
      c_ADDR_MASK:   w_rd_next[WIDTH-1:0] = r_mask;
      c_ADDR_PERIOD: w_rd_next[23:0]      = r_period;
      default:       w_rd_next            = {7'd0, r_phase, r_cnt};
    endcase
  end

  // LED drive: masked bits gated by phase, the rest follow DATA
  assign w_out_next = (r_data & ~r_mask) | (r_data & r_mask & {WIDTH{r_phase}});

  // Registered read data, one cycle after the address is presented
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rd_next;
    end
  end

  // Registered LED outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= DATA_RESET;
    end else begin
      r_out <= w_out_next;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out;

endmodule
`default_nettype wire
